// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin 4:1 arbiter with burst-limited grants and a registered select
// that steers a 4:1 data mux toward a single ready/valid consumer.
module mux_4x1_rr_arbiter #(
    parameter int unsigned DW   = 8,
    parameter int unsigned MAXB = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
    input  logic            out_ready,
    output logic [3:0]      grant,
    output logic [1:0]      s,
    output logic            out_valid,
    output logic [DW-1:0]   dout,
    output logic            busy
);

    localparam logic [3:0] LAST = 4'(MAXB - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state, state_n;
    logic [3:0] grant_n;
    logic [1:0] s_n;
    logic [1:0] ptr, ptr_n;
    logic [3:0] cnt, cnt_n;

    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic       xfer;

    // First requester found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign busy      = (state == GRANT);
    assign out_valid = busy && req[s];
    assign xfer      = out_valid && out_ready;
    assign dout      = out_valid ? din[DW*int'(s) +: DW] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            s     <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            s     <= s_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    // Grant ends when the burst limit is reached or the owner withdraws;
    // the owner then drops to lowest priority.
    always_comb begin
        state_n = state;
        grant_n = grant;
        s_n     = s;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (found) begin
                    state_n = GRANT;
                    s_n     = pick;
                    grant_n = 4'b0001 << pick;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_n = cnt + 4'd1;
                end
                if (!req[s] || (xfer && cnt == LAST)) begin
                    state_n = IDLE;
                    grant_n = '0;
                    ptr_n   = s + 2'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed bench for mux_4x1_rr_arbiter: rotation, stalls, early release,
// mid-burst reset, and per-cycle grant/select/busy invariants.
module tb_mux_4x1_rr_arbiter;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [7:0]    w [4];
    logic [4*DW-1:0] din;
    logic          out_ready;
    logic [3:0]    grant;
    logic [1:0]    s;
    logic          out_valid;
    logic [DW-1:0] dout;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    assign din = {w[3], w[2], w[1], w[0]};

    mux_4x1_rr_arbiter #(.DW(DW), .MAXB(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .grant     (grant),
        .s         (s),
        .out_valid (out_valid),
        .dout      (dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 2 time units after the edge, check invariants.
    task automatic cyc();
        @(posedge clk);
        #2;
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
        chk("grant_s_eq_busy", 32'(grant[s]), 32'(busy));
        chk("valid_implies_busy", 32'(!out_valid || busy), 32'd1);
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
    endtask

    task automatic exp_own(input string tag, input int o, input logic [7:0] d);
        chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << o));
        chk({tag, "_s"}, 32'(s), 32'(o));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_dout"}, 32'(dout), 32'(d));
    endtask

    initial begin
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        req = 4'b0000;
        out_ready = 1'b0;
        rst = 1'b1;
        #3;
        exp_idle("rst");
        chk("rst_s", 32'(s), 32'd0);
        cyc();
        rst = 1'b0;

        // No requests: stays idle.
        for (int i = 0; i < 10; i++) begin
            cyc();
            exp_idle("noreq");
        end

        // All requesting: strict rotation 0,1,2,3,0 with 4 beats each and a bubble.
        req = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < 4; b++) begin
                cyc();
                exp_own("rot", i % 4, w[i % 4]);
            end
            cyc();
            exp_idle("rot_bubble");
        end
        req = 4'b0000;
        cyc();
        exp_idle("rot_end");

        // Stall: owner 2 held with out_ready low, beats only count once ready.
        w[2] = 8'hA5;
        req = 4'b0100;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_own("stall", 2, 8'hA5);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_own("stall_go", 2, 8'hA5);
        end
        cyc();
        exp_idle("stall_done");
        req = 4'b0000;

        // Owner 1 withdraws after two beats while 3 is waiting.
        req = 4'b0010;
        cyc();
        exp_own("own1", 1, 8'h22);
        req = 4'b1010;
        cyc();
        exp_own("own1_b1", 1, 8'h22);
        cyc();
        exp_own("own1_b2", 1, 8'h22);
        req = 4'b1000;
        #1;
        chk("drop_valid", 32'(out_valid), 32'd0);
        chk("drop_dout", 32'(dout), 32'd0);
        chk("drop_busy", 32'(busy), 32'd1);
        cyc();
        exp_idle("drop_exit");
        req = 4'b1010;
        cyc();
        exp_own("next3", 3, 8'h44);
        req = 4'b0000;
        cyc();
        exp_idle("own3_exit");

        // Short owner-2 grant leaves ptr at 3.
        req = 4'b0100;
        cyc();
        exp_own("own2a", 2, 8'hA5);
        req = 4'b0000;
        cyc();
        exp_idle("own2a_exit");

        // Reset during owner 2's third beat; rearbitration scans from 0.
        req = 4'b0100;
        cyc();
        exp_own("own2b_b0", 2, 8'hA5);
        cyc();
        exp_own("own2b_b1", 2, 8'hA5);
        cyc();
        exp_own("own2b_b2", 2, 8'hA5);
        rst = 1'b1;
        #1;
        exp_idle("midrst");
        chk("midrst_s", 32'(s), 32'd0);
        req = 4'b1100;
        cyc();
        exp_idle("rst_hold");
        rst = 1'b0;
        cyc();
        exp_own("post_rst", 2, 8'hA5);
        cyc();
        exp_own("post_rst_b1", 2, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
